// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter, one byte in flight at a time.
// Bytes are pushed at any rate; the issue FSM pops one and strobes it out, then waits
// for the transmitter to visibly accept it (tx_busy rises) and finish it (tx_busy falls).
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            tx_din,
  output logic                  tx_wr_en,
  input  logic                  tx_busy,
  output logic                  idle
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  in_ready_reg;
  logic                  overflow_reg;
  logic [7:0]            tx_din_reg;
  logic                  tx_wr_en_reg;
  logic                  tx_wr_en_next;
  state_t                state_reg;
  state_t                state_next;
  logic                  push;
  logic                  pop;
  logic                  empty;

  // A push is judged against the registered ready flag, so a pop in the same
  // cycle never makes room for that cycle's push.
  assign push  = in_valid && in_ready_reg;
  assign empty = (level_reg == '0);

  // Occupancy bookkeeping: push and pop in the same cycle cancel out.
  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LEVEL_ONE;
    end else if (pop && !push) begin
      level_next = level_reg - LEVEL_ONE;
    end
  end

  // Storage write port; contents are not reset so the array maps onto block RAM.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // Pointers, level, ready flag and sticky overflow (a new overflow beats a clear).
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      in_ready_reg <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      level_reg    <= level_next;
      in_ready_reg <= (level_next != LEVEL_FULL);
      if (in_valid && !in_ready_reg) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Issue FSM next-state logic; the pop and the strobe happen together on leaving S_IDLE.
  always_comb begin
    state_next    = state_reg;
    tx_wr_en_next = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop           = 1'b1;
          tx_wr_en_next = 1'b1;
          state_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // The transmitter raises tx_busy one cycle after its wr_en.
        if (tx_busy) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; tx_din is the registered RAM read and holds until the next pop.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      tx_wr_en_reg <= 1'b0;
      tx_din_reg   <= 8'h00;
    end else begin
      state_reg    <= state_next;
      tx_wr_en_reg <= tx_wr_en_next;
      if (pop) begin
        tx_din_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign in_ready = in_ready_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign tx_din   = tx_din_reg;
  assign tx_wr_en = tx_wr_en_reg;
  assign idle     = empty && (state_reg == S_IDLE) && !tx_busy;

endmodule
